cp0_timed: RTL and testbench

CP0_TIMED -- requirements
Module: cp0_timed

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_timer.sv | 67 ++++++
 rtl/cp0_timed.sv | 118 +++++++++++
 tb/tb_cp0_timed.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and EPC helper
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Word-aligned trap PC; a delay-slot fault restarts at the branch.
  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic in_ds);
    logic [31:0] w_base;
    w_base = {pc[31:2], 2'b00};
    return in_ds ? (w_base - 32'd4) : w_base;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky TI
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic        we_ti,
  input  logic        ti_wdata,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_inc;
  logic          r_ti;
  logic          w_tick;

  assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

  // Prescaler and Count; a Count write restarts the prescale period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_count <= '0;
      r_inc   <= 1'b0;
    end else if (we_count) begin
      r_presc <= '0;
      r_count <= wr_data;
      r_inc   <= 1'b0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_count <= r_count + 32'd1;
      r_inc   <= 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_inc   <= 1'b0;
    end
  end

  // Compare register.
  always_ff @(posedge clk) begin
    if (rst)             r_compare <= '0;
    else if (we_compare) r_compare <= wr_data;
  end

  // TI: set only the cycle after an increment lands on Compare; Compare write clears it first.
  always_ff @(posedge clk) begin
    if (rst)                                 r_ti <= 1'b0;
    else if (we_compare)                     r_ti <= 1'b0;
    else if (we_ti)                          r_ti <= ti_wdata;
    else if (r_inc && r_count == r_compare)  r_ti <= 1'b1;
  end

endmodule

// File: rtl/cp0_timed.sv
// rtl/cp0_timed.sv - CP0 with SR/Cause/EPC/PRId, trap logic and timer
module cp0_timed
  import cp0_pkg::*;
#(
  parameter int          N_HWINT  = 6,
  parameter int          TICK_DIV = 1,
  parameter logic [31:0] PRID     = 32'h0000_8001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               we,
  input  logic               eret,
  input  logic               in_delay_slot,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc_now,
  output logic [31:0]        epc,
  output logic               go_handle,
  output logic               timer_irq
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr;
  logic        w_wr_sr;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;

  // Pending bits: hardware lines pass straight through, IP[7] is the timer.
  always_comb begin
    w_ip              = '0;
    w_ip[N_HWINT-1:0] = hw_int;
    w_ip[7]           = w_ti;
  end

  assign w_int_req  = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc_req  = (exc_code != 5'd0) & ~r_exl;
  assign go_handle  = w_int_req | w_exc_req;
  assign w_wr       = we & ~go_handle;
  assign w_wr_sr    = w_wr && (wr_addr == CP0_SR);
  assign w_wr_cause = w_wr && (wr_addr == CP0_CAUSE);
  assign w_wr_epc   = w_wr && (wr_addr == CP0_EPC);
  assign epc        = r_epc;
  assign timer_irq  = w_ti;

  cp0_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .we_count   (w_wr && (wr_addr == CP0_COUNT)),
    .we_compare (w_wr && (wr_addr == CP0_COMPARE)),
    .we_ti      (w_wr_cause),
    .ti_wdata   (wr_data[15]),
    .wr_data    (wr_data),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  // SR/Cause/EPC: trap entry overrides software writes and eret.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_exc <= '0;
      r_epc <= '0;
    end else if (go_handle) begin
      r_exl <= 1'b1;
      r_bd  <= in_delay_slot;
      r_exc <= w_int_req ? 5'(EXC_INT) : exc_code;
      r_epc <= trap_epc(pc_now, in_delay_slot);
    end else begin
      if (w_wr_sr) begin
        r_im  <= wr_data[15:8];
        r_exl <= wr_data[1];
        r_ie  <= wr_data[0];
      end else if (eret) begin
        r_exl <= 1'b0;
      end
      if (w_wr_cause) begin
        r_bd  <= wr_data[31];
        r_exc <= wr_data[6:2];
      end
      if (w_wr_epc) r_epc <= wr_data;
    end
  end

  // Read mux returns the current (pre-write) register contents.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_COUNT:   rd_data = w_count;
      CP0_COMPARE: rd_data = w_compare;
      CP0_SR:      rd_data = {16'b0, r_im, 6'b0, r_exl, r_ie};
      CP0_CAUSE:   rd_data = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exc, 2'b00};
      CP0_EPC:     rd_data = r_epc;
      CP0_PRID:    rd_data = PRID;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timed.sv
// tb/tb_cp0_timed.sv - randomized and directed bench for cp0_timed against a reference model
module tb_cp0_timed;

  localparam int          NH = 6;
  localparam int          TD = 4;
  localparam logic [31:0] PR = 32'h0000_8001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          we;
  logic          eret;
  logic          in_delay_slot;
  logic [NH-1:0] hw_int;
  logic [4:0]    exc_code;
  logic [31:0]   pc_now;
  logic [31:0]   epc;
  logic          go_handle;
  logic          timer_irq;

  cp0_timed #(.N_HWINT(NH), .TICK_DIV(TD), .PRID(PR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .we(we), .eret(eret),
    .in_delay_slot(in_delay_slot), .hw_int(hw_int), .exc_code(exc_code),
    .pc_now(pc_now), .epc(epc), .go_handle(go_handle), .timer_irq(timer_irq)
  );

  // staged stimulus, applied just after each rising edge
  logic          s_rst, s_we, s_eret, s_ds;
  logic [4:0]    s_rd_addr, s_wr_addr, s_exc;
  logic [31:0]   s_wr_data, s_pc;
  logic [NH-1:0] s_hw;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // reference model: architectural state after the most recently applied cycle
  logic [31:0] m_count, m_compare, m_epc;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  logic        m_exl, m_ie, m_bd, m_ti, m_inc, m_valid;
  int          m_phase;

  function automatic logic [7:0] m_ip();
    return {m_ti, 7'b0} | 8'(hw_int);
  endfunction

  function automatic logic m_int_req();
    return (|(m_ip() & m_im)) && m_ie && !m_exl;
  endfunction

  function automatic logic m_go();
    return m_int_req() || ((exc_code != 5'd0) && !m_exl);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'b0, m_im, 6'b0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc;
      5'd15:   return PR;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle();
    s_rst = 0; s_we = 0; s_eret = 0; s_ds = 0; s_rd_addr = 5'd0; s_wr_addr = 5'd0;
    s_exc = 5'd0; s_wr_data = 32'd0; s_pc = 32'd0; s_hw = '0;
  endtask

  // one clock: apply stimulus, compare combinational outputs, advance the model
  task automatic step();
    logic go, ireq, wev, ti_n;
    @(posedge clk);
    #1;
    rst = s_rst; we = s_we; eret = s_eret; in_delay_slot = s_ds; rd_addr = s_rd_addr;
    wr_addr = s_wr_addr; exc_code = s_exc; wr_data = s_wr_data; pc_now = s_pc; hw_int = s_hw;
    #1;
    ireq = m_int_req();
    go   = m_go();
    if (m_valid && !rst) begin
      check("go_handle", {31'd0, go_handle}, {31'd0, go});
      check("rd_data", rd_data, m_read(rd_addr));
      check("epc", epc, m_epc);
      check("timer_irq", {31'd0, timer_irq}, {31'd0, m_ti});
    end
    if (rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_im = 0; m_exc = 0;
      m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_inc = 0; m_phase = 0; m_valid = 1;
    end else begin
      wev  = we && !go;
      ti_n = m_ti;
      if (wev && wr_addr == 5'd11)                ti_n = 1'b0;
      else if (wev && wr_addr == 5'd13)           ti_n = wr_data[15];
      else if (m_inc && m_count == m_compare)     ti_n = 1'b1;
      if (wev && wr_addr == 5'd9) begin
        m_count = wr_data; m_phase = 0; m_inc = 0;
      end else begin
        m_phase = (m_phase + 1) % TD;
        m_inc   = (m_phase == 0);
        if (m_inc) m_count = m_count + 1;
      end
      if (wev && wr_addr == 5'd11) m_compare = wr_data;
      m_ti = ti_n;
      if (go) begin
        m_exl = 1; m_bd = in_delay_slot;
        m_exc = ireq ? 5'd0 : exc_code;
        m_epc = (pc_now & ~32'd3) - (in_delay_slot ? 32'd4 : 32'd0);
      end else begin
        if (wev && wr_addr == 5'd12) begin
          m_im = wr_data[15:8]; m_exl = wr_data[1]; m_ie = wr_data[0];
        end else if (eret) begin
          m_exl = 0;
        end
        if (wev && wr_addr == 5'd13) begin
          m_bd = wr_data[31]; m_exc = wr_data[6:2];
        end
        if (wev && wr_addr == 5'd14) m_epc = wr_data;
      end
    end
  endtask

  task automatic idle_step();
    idle(); step();
  endtask

  task automatic do_reset();
    idle(); s_rst = 1; step(); s_rst = 0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    idle(); s_we = 1; s_wr_addr = a; s_wr_data = d; step();
  endtask

  task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  logic [4:0] regs[7]  = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
  logic [4:0] codes[4] = '{5'd4, 5'd5, 5'd10, 5'd12};

  initial begin
    m_valid = 0; m_phase = 0;
    m_count = 0; m_compare = 0; m_epc = 0; m_im = 0; m_exc = 0;
    m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_inc = 0;
    idle();
    rst = 1; we = 0; eret = 0; in_delay_slot = 0; rd_addr = 0; wr_addr = 0;
    exc_code = 0; wr_data = 0; pc_now = 0; hw_int = '0;

    // reset state and constant registers
    do_reset();
    idle_step();
    peek(5'd12, "rst_sr", 32'd0);
    peek(5'd13, "rst_cause", 32'd0);
    peek(5'd15, "prid", PR);
    peek(5'd7, "unmapped", 32'd0);

    // hardware interrupt trap
    do_reset();
    write(5'd12, 32'h0000_FC01);
    idle(); s_hw = 6'b000100; s_pc = 32'h0000_1000; step();
    check("A_go", {31'd0, go_handle}, 32'd1);
    idle_step();
    peek(5'd12, "A_sr", 32'h0000_FC03);
    peek(5'd13, "A_cause", 32'd0);
    peek(5'd14, "A_epc", 32'h0000_1000);

    // overflow in delay slot
    do_reset();
    idle(); s_exc = 5'd12; s_ds = 1; s_pc = 32'h0000_3008; step();
    idle_step();
    peek(5'd14, "B_epc", 32'h0000_3004);
    peek(5'd13, "B_cause", 32'h8000_0030);

    // timer match, timer trap, Compare write clears TI
    do_reset();
    write(5'd11, 32'd3);
    write(5'd9, 32'd0);
    for (int j = 1; j <= 15; j++) begin
      idle_step();
      check($sformatf("C_ti_%0d", j - 1), {31'd0, timer_irq}, {31'd0, (j >= 14)});
    end
    write(5'd12, 32'h0000_8001);
    idle_step();
    check("C_tgo", {31'd0, go_handle}, 32'd1);
    idle_step();
    peek(5'd13, "C_cause", 32'h4000_8000);
    write(5'd11, 32'h0000_0100);
    idle_step();
    check("C_ticlr", {31'd0, timer_irq}, 32'd0);

    // Count wrap without a spurious match
    do_reset();
    write(5'd11, 32'd5);
    write(5'd9, 32'hFFFF_FFFF);
    for (int j = 0; j < 5; j++) idle_step();
    peek(5'd9, "D_wrap", 32'd0);
    idle_step(); idle_step();
    check("D_noti", {31'd0, timer_irq}, 32'd0);

    // EPC write loses to trap; eret clears EXL
    do_reset();
    idle(); s_exc = 5'd4; s_pc = 32'h0000_2000; s_we = 1; s_wr_addr = 5'd14;
    s_wr_data = 32'hDEAD_BEEF; step();
    check("E_go", {31'd0, go_handle}, 32'd1);
    idle_step();
    peek(5'd14, "E_epc", 32'h0000_2000);
    peek(5'd12, "E_exl", 32'h0000_0002);
    idle(); s_eret = 1; step();
    idle_step();
    peek(5'd12, "E_eret", 32'd0);

    // reset mid-count with TI pending
    do_reset();
    write(5'd11, 32'h40);
    write(5'd9, 32'h3F);
    for (int j = 0; j < 6; j++) idle_step();
    check("F_ti", {31'd0, timer_irq}, 32'd1);
    peek(5'd9, "F_cnt", 32'h40);
    do_reset();
    idle_step();
    check("F_go", {31'd0, go_handle}, 32'd0);
    check("F_epc", epc, 32'd0);
    check("F_tirq", {31'd0, timer_irq}, 32'd0);
    peek(5'd9, "F_count", 32'd0);
    peek(5'd11, "F_compare", 32'd0);
    peek(5'd12, "F_sr", 32'd0);
    peek(5'd13, "F_cause", 32'd0);

    // randomized traffic checked every cycle against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      idle();
      s_rd_addr = regs[$urandom_range(0, 6)];
      s_rst     = ($urandom_range(0, 99) < 2);
      s_we      = ($urandom_range(0, 3) == 0);
      s_wr_addr = regs[$urandom_range(0, 6)];
      case (s_wr_addr)
        5'd11:   s_wr_data = m_count + $urandom_range(0, 12);
        5'd12:   s_wr_data = $urandom & 32'h0000_FF03;
        5'd9:    s_wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 40);
        default: s_wr_data = $urandom;
      endcase
      s_eret = ($urandom_range(0, 7) == 0);
      s_exc  = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
      s_hw   = ($urandom_range(0, 5) == 0) ? NH'($urandom) : '0;
      s_ds   = 1'($urandom);
      s_pc   = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
